// File: rtl/bus_rtc_ctrl.sv
// Multiplexed address/data bus master for an RTC-style peripheral.
// Each beat runs ADDR_SU, ADDR_STB, GAP, DATA_STB and TURN. All pad-facing
// outputs are registered and change on the same edge as the state.
module bus_rtc_ctrl #(
  parameter int unsigned DW     = 8,
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_STB  = 7,
  parameter int unsigned T_GAP  = 11,
  parameter int unsigned T_TURN = 5
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          start,
  input  logic          rw,
  input  logic [DW-1:0] addr,
  input  logic [3:0]    burst,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] ad_in,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  output logic          CS,
  output logic          RD,
  output logic          WR,
  output logic          A_D,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [3:0]    beat
);

  // Phase counter must hold the longest state duration minus one.
  // All timing parameters are expected to be >= 1, with T_STB >= 2.
  localparam int unsigned MAX_AB = (T_SU > T_STB) ? T_SU : T_STB;
  localparam int unsigned MAX_CD = (T_GAP > T_TURN) ? T_GAP : T_TURN;
  localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_T + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR_SU  = 3'd1;
  localparam logic [2:0] S_ADDR_STB = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DATA_STB = 3'd4;
  localparam logic [2:0] S_TURN     = 3'd5;

  logic [2:0]    state_q,  state_nxt;
  logic [CW-1:0] cnt_q,    cnt_nxt;
  logic          rw_q,     rw_nxt;
  logic [DW-1:0] addr_q,   addr_nxt;
  logic [3:0]    burst_q,  burst_nxt;
  logic [3:0]    beat_nxt;
  logic [DW-1:0] ad_out_nxt;
  logic          ad_oe_nxt;
  logic          cs_nxt;
  logic          rd_nxt;
  logic          wr_nxt;
  logic          a_d_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          rvalid_nxt;

  // Next state, phase timing, transaction bookkeeping and next bus outputs.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    rw_nxt     = rw_q;
    addr_nxt   = addr_q;
    burst_nxt  = burst_q;
    beat_nxt   = beat;
    done_nxt   = 1'b0;
    rvalid_nxt = 1'b0;
    rdata_nxt  = rdata;

    if (state_q == S_IDLE) begin
      if (start) begin
        state_nxt = S_ADDR_SU;
        cnt_nxt   = CW'(T_SU - 1);
        rw_nxt    = rw;
        addr_nxt  = addr;
        burst_nxt = burst;
        beat_nxt  = 4'd0;
      end
    end else if (cnt_q != CW'(0)) begin
      cnt_nxt = cnt_q - CW'(1);
    end else begin
      case (state_q)
        S_ADDR_SU: begin
          state_nxt = S_ADDR_STB;
          cnt_nxt   = CW'(T_STB - 1);
        end
        S_ADDR_STB: begin
          state_nxt = S_GAP;
          cnt_nxt   = CW'(T_GAP - 1);
        end
        S_GAP: begin
          state_nxt = S_DATA_STB;
          cnt_nxt   = CW'(T_STB - 1);
        end
        S_DATA_STB: begin
          state_nxt = S_TURN;
          cnt_nxt   = CW'(T_TURN - 1);
          // Read data is taken on the last strobe cycle.
          if (rw_q) begin
            rdata_nxt  = ad_in;
            rvalid_nxt = 1'b1;
          end
        end
        S_TURN: begin
          if (beat < burst_q) begin
            state_nxt = S_ADDR_SU;
            cnt_nxt   = CW'(T_SU - 1);
            beat_nxt  = beat + 4'd1;
            addr_nxt  = addr_q + DW'(1);
          end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = CW'(0);
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = CW'(0);
        end
      endcase
    end

    // Bus outputs are decoded from the state being entered.
    ad_out_nxt = '0;
    ad_oe_nxt  = 1'b0;
    cs_nxt     = 1'b1;
    rd_nxt     = 1'b1;
    wr_nxt     = 1'b1;
    a_d_nxt    = 1'b1;
    busy_nxt   = (state_nxt != S_IDLE);
    case (state_nxt)
      S_ADDR_SU: begin
        a_d_nxt    = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
      end
      S_ADDR_STB: begin
        a_d_nxt    = 1'b0;
        cs_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
      end
      S_DATA_STB: begin
        cs_nxt = 1'b0;
        if (rw_nxt) begin
          rd_nxt = 1'b0;
        end else begin
          wr_nxt     = 1'b0;
          ad_oe_nxt  = 1'b1;
          // Write data is sampled once, on entry, then held.
          ad_out_nxt = (state_q == S_DATA_STB) ? ad_out : wdata;
        end
      end
      default: begin
        ad_out_nxt = '0;
      end
    endcase
  end

  // State, bookkeeping and registered outputs with synchronous reset.
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      burst_q <= '0;
      beat    <= '0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      CS      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      A_D     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      burst_q <= burst_nxt;
      beat    <= beat_nxt;
      ad_out  <= ad_out_nxt;
      ad_oe   <= ad_oe_nxt;
      CS      <= cs_nxt;
      RD      <= rd_nxt;
      WR      <= wr_nxt;
      A_D     <= a_d_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
      rvalid  <= rvalid_nxt;
    end
  end

endmodule

// File: tb/tb_bus_rtc_ctrl.sv
// Self-checking bench for bus_rtc_ctrl: per-cycle expected bus waveform is
// derived from the beat period arithmetic and captured stimulus values.
module tb_bus_rtc_ctrl;

  localparam int T_SU   = 2;
  localparam int T_STB  = 7;
  localparam int T_GAP  = 11;
  localparam int T_TURN = 5;
  localparam int P      = T_SU + 2 * T_STB + T_GAP + T_TURN;
  localparam int E_SU   = T_SU;
  localparam int E_ASTB = E_SU + T_STB;
  localparam int E_GAP  = E_ASTB + T_GAP;
  localparam int E_DSTB = E_GAP + T_STB;

  logic       reloj;
  logic       resetM;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [3:0] burst;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       CS;
  logic       RD;
  logic       WR;
  logic       A_D;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rvalid;
  logic [3:0] beat;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_rdata;

  bus_rtc_ctrl #(
    .DW(8), .T_SU(T_SU), .T_STB(T_STB), .T_GAP(T_GAP), .T_TURN(T_TURN)
  ) dut (
    .reloj(reloj), .resetM(resetM), .start(start), .rw(rw), .addr(addr),
    .burst(burst), .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .CS(CS), .RD(RD), .WR(WR), .A_D(A_D), .busy(busy),
    .done(done), .rdata(rdata), .rvalid(rvalid), .beat(beat)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Idle cycles: bus released, no pulses, rdata holds.
  task automatic idle_cycles(input int k);
    logic [7:0] act;
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge reloj); #1;
      act = {CS, RD, WR, A_D, ad_oe, busy, done, rvalid};
      vectors++;
      if (act !== 8'b1111_0000) begin
        miscompares++;
        $display("FAIL idle_strobes: got %b want %b", act, 8'b1111_0000);
      end
      vectors++;
      if (rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL idle_rdata: got %h want %h", rdata, exp_rdata);
      end
    end
  endtask

  // One transaction from the current cycle (cycle 0 presents start).
  task automatic run_txn(input logic r, input logic [7:0] a, input logic [3:0] bl,
                         input logic [7:0] dfix, input bit use_fix,
                         input bit glitch, input int abort_n);
    int         n_end;
    int         m, b, p;
    logic [7:0] cap_w, cap_r, exp_ad, exp_vec, act_vec;
    n_end = P * (int'(bl) + 1) + 1;
    cap_w = 8'h00;
    cap_r = 8'h00;
    start = 1'b1;
    rw    = r;
    addr  = a;
    burst = bl;
    wdata = use_fix ? dfix : 8'($urandom);
    ad_in = use_fix ? dfix : 8'($urandom);
    for (int n = 1; n <= n_end; n++) begin
      @(posedge reloj); #1;
      m      = n - 1;
      b      = m / P;
      p      = m % P;
      exp_ad = a + 8'(b);
      if (n == n_end)       exp_vec = 8'b1111_0010;
      else if (p < E_SU)    exp_vec = 8'b1110_1100;
      else if (p < E_ASTB)  exp_vec = 8'b0100_1100;
      else if (p < E_GAP)   exp_vec = 8'b1111_0100;
      else if (p < E_DSTB) begin
        exp_vec = r ? 8'b0011_0100 : 8'b0101_1100;
        exp_ad  = cap_w;
      end else begin
        exp_vec = {7'b1111_010, (r && p == E_DSTB)};
        if (r && p == E_DSTB) exp_rdata = cap_r;
      end
      act_vec = {CS, RD, WR, A_D, ad_oe, busy, done, rvalid};
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL txn_strobes n=%0d: got %b want %b", n, act_vec, exp_vec);
      end
      if (n < n_end) begin
        vectors++;
        if (beat !== 4'(b)) begin
          miscompares++;
          $display("FAIL txn_beat n=%0d: got %0d want %0d", n, beat, b);
        end
      end
      if (exp_vec[3]) begin
        vectors++;
        if (ad_out !== exp_ad) begin
          miscompares++;
          $display("FAIL txn_ad_out n=%0d: got %h want %h", n, ad_out, exp_ad);
        end
      end
      vectors++;
      if (rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL txn_rdata n=%0d: got %h want %h", n, rdata, exp_rdata);
      end
      if (n == abort_n) begin
        resetM = 1'b0;
        start  = 1'b0;
        @(posedge reloj); #1;
        exp_rdata = 8'h00;
        act_vec = {CS, RD, WR, A_D, ad_oe, busy, done, rvalid};
        vectors++;
        if (act_vec !== 8'b1111_0000) begin
          miscompares++;
          $display("FAIL abort_strobes: got %b want %b", act_vec, 8'b1111_0000);
        end
        vectors++;
        if ({ad_out, rdata, beat} !== 20'h0) begin
          miscompares++;
          $display("FAIL abort_regs: got %h/%h/%0d want 00/00/0", ad_out, rdata, beat);
        end
        resetM = 1'b1;
        idle_cycles(1);
        return;
      end
      // Drive this cycle's inputs; stray starts while busy must be ignored.
      start = glitch && (n < n_end) && ($urandom_range(0, 5) == 0);
      if (start) begin
        rw    = 1'($urandom);
        addr  = 8'($urandom);
        burst = 4'($urandom);
      end
      wdata = use_fix ? dfix : 8'($urandom);
      ad_in = use_fix ? dfix : 8'($urandom);
      if (n < n_end && p == E_GAP - 1)  cap_w = wdata;
      if (n < n_end && p == E_DSTB - 1) cap_r = ad_in;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] act;
    resetM = 1'b0;
    start  = 1'b0;
    rw     = 1'b0;
    addr   = 8'h00;
    burst  = 4'h0;
    wdata  = 8'h00;
    ad_in  = 8'h00;
    exp_rdata = 8'h00;
    repeat (2) @(posedge reloj);
    #1;
    act = {CS, RD, WR, A_D, ad_oe, busy, done, rvalid};
    vectors++;
    if (act !== 8'b1111_0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want %b", act, 8'b1111_0000);
    end
    vectors++;
    if ({ad_out, rdata, beat} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h/%h/%0d want 00/00/0", ad_out, rdata, beat);
    end
    resetM = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_write_single;
    run_txn(1'b0, 8'h2A, 4'd0, 8'h55, 1'b1, 1'b0, 0);
    idle_cycles(3);
  endtask

  task automatic test_read_single;
    run_txn(1'b1, 8'h0D, 4'd0, 8'hA7, 1'b1, 1'b0, 0);
    idle_cycles(2);
  endtask

  task automatic test_burst_wrap;
    run_txn(1'b0, 8'hFE, 4'd2, 8'h00, 1'b0, 1'b0, 0);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 8'($urandom), 4'd1, 8'h00, 1'b0, 1'b1, 0);
    run_txn(1'b0, 8'($urandom), 4'd0, 8'h00, 1'b0, 1'b1, 0);
    run_txn(1'b1, 8'hFF, 4'd1, 8'h00, 1'b0, 1'b0, 0);
    idle_cycles(2);
  endtask

  task automatic test_reset_abort;
    run_txn(1'b1, 8'h30, 4'd3, 8'h00, 1'b0, 1'b0, P + 5);
    run_txn(1'b0, 8'h10, 4'd0, 8'h3C, 1'b1, 1'b0, 0);
    idle_cycles(1);
  endtask

  task automatic test_random;
    logic [3:0] bl;
    int         ab;
    for (int t = 0; t < 8; t++) begin
      bl = 4'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P * (int'(bl) + 1)) : 0;
      run_txn(1'($urandom), 8'($urandom), bl, 8'h00, 1'b0, 1'($urandom), ab);
      if (ab == 0 && $urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_write_single;
    test_read_single;
    test_burst_wrap;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
